// File: rtl/ahb_secded_responder_if.sv
// AHB-Lite data-bus bundle for the SECDED responder: address/control, write data with
// checksum, read data with checksum, and the response/parity-error outputs.
interface ahb_secded_responder_if;
  logic        s_hsel_i;
  logic [31:0] s_haddr_i;
  logic [1:0]  s_htrans_i;
  logic [2:0]  s_hsize_i;
  logic        s_hwrite_i;
  logic [5:0]  s_hparity_i;
  logic        s_hready_i;
  logic [31:0] s_hwdata_i;
  logic [6:0]  s_hwdcheck_i;
  logic [31:0] s_hrdata_o;
  logic [6:0]  s_hrdcheck_o;
  logic        s_hreadyout_o;
  logic        s_hresp_o;
  logic        s_perr_o;

  modport slave (
    input  s_hsel_i, s_haddr_i, s_htrans_i, s_hsize_i, s_hwrite_i, s_hparity_i,
           s_hready_i, s_hwdata_i, s_hwdcheck_i,
    output s_hrdata_o, s_hrdcheck_o, s_hreadyout_o, s_hresp_o, s_perr_o
  );

  modport master (
    output s_hsel_i, s_haddr_i, s_htrans_i, s_hsize_i, s_hwrite_i, s_hparity_i,
           s_hready_i, s_hwdata_i, s_hwdcheck_i,
    input  s_hrdata_o, s_hrdcheck_o, s_hreadyout_o, s_hresp_o, s_perr_o
  );
endinterface

// File: rtl/ahb_secded_responder.sv
// AHB-Lite responder over a word memory storing 32-bit data plus 7-bit SECDED check;
// address-phase parity/range/size/alignment checks, narrow-write merge with re-encode.
module ahb_secded_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic                    s_clk_i,
  input logic                    s_resetn_i,
  ahb_secded_responder_if.slave  s
);

  localparam int unsigned AW         = $clog2(MEM_WORDS);
  localparam logic [2:0]  WCNT_INIT  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam logic [32:0] RANGE_END  = 33'(MEM_WORDS) << 2;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_ERR1, S_ERR2} state_e;

  // Hamming(38,32) over positions 1..38 (check bits at powers of two) plus overall parity.
  function automatic logic [6:0] secded_enc(input logic [31:0] d);
    logic [6:0] c;
    int         k;
    c = '0;
    k = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int j = 0; j < 6; j++) begin
          if (p[j]) c[j] = c[j] ^ d[k];
        end
        k++;
      end
    end
    c[6] = (^d) ^ (^c[5:0]);
    return c;
  endfunction

  logic [38:0]   mem_q [MEM_WORDS];

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    off_q, off_d;
  logic [1:0]    size_q, size_d;
  logic          write_q, write_d;
  logic [2:0]    wcnt_q, wcnt_d;
  logic          perr_q, perr_d;

  logic          accept, par_err, addr_err;
  logic [31:0]   offset;
  logic [5:0]    par_exp;
  logic [38:0]   rd_word, wr_word;
  logic [31:0]   stored_d, merged;
  logic [6:0]    stored_c, syn;
  logic [3:0]    be;
  logic          narrow, ready, resp, we, rd_en, take;

  assign accept  = s.s_hsel_i & s.s_hready_i & s.s_htrans_i[1];
  assign offset  = s.s_haddr_i - BASE_ADDR;
  assign par_exp = {^s.s_htrans_i, (^s.s_hsize_i) ^ s.s_hwrite_i,
                    ^s.s_haddr_i[31:24], ^s.s_haddr_i[23:16],
                    ^s.s_haddr_i[15:8],  ^s.s_haddr_i[7:0]};
  assign par_err  = par_exp != s.s_hparity_i;
  assign addr_err = par_err
                  | ({1'b0, offset} >= RANGE_END)
                  | (s.s_hsize_i > 3'b010)
                  | ((s.s_hsize_i == 3'b001) & offset[0])
                  | ((s.s_hsize_i == 3'b010) & (offset[1:0] != 2'b00));

  assign rd_word  = mem_q[idx_q];
  assign stored_d = rd_word[31:0];
  assign stored_c = rd_word[38:32];
  assign narrow   = size_q != 2'b10;

  always_comb begin
    be     = 4'b1111;
    merged = stored_d;
    syn    = secded_enc(stored_d) ^ stored_c;
    case (size_q)
      2'b00:   be = 4'b0001 << off_q;
      2'b01:   be = off_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = s.s_hwdata_i[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    wcnt_d  = wcnt_q;
    perr_d  = 1'b0;
    ready   = 1'b1;
    resp    = 1'b0;
    we      = 1'b0;
    rd_en   = 1'b0;
    take    = 1'b0;
    wr_word = {s.s_hwdcheck_i, s.s_hwdata_i};
    case (state_q)
      S_IDLE: take = 1'b1;
      S_WAIT: begin
        ready = 1'b0;
        if (wcnt_q == 3'd0) state_d = S_ACCESS;
        else                wcnt_d  = wcnt_q - 3'd1;
      end
      S_ACCESS: begin
        // A narrow write into a word that already fails its check is refused, not merged.
        if (write_q && narrow && (syn != 7'd0)) begin
          ready   = 1'b0;
          resp    = 1'b1;
          state_d = S_ERR2;
        end else begin
          rd_en   = ~write_q;
          we      = write_q;
          if (narrow) wr_word = {secded_enc(merged), merged};
          state_d = S_IDLE;
          take    = 1'b1;
        end
      end
      S_ERR1: begin
        ready   = 1'b0;
        resp    = 1'b1;
        state_d = S_ERR2;
      end
      S_ERR2: begin
        resp    = 1'b1;
        state_d = S_IDLE;
        take    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (take && accept) begin
      idx_d   = offset[AW+1:2];
      off_d   = offset[1:0];
      size_d  = s.s_hsize_i[1:0];
      write_d = s.s_hwrite_i;
      perr_d  = par_err;
      if (addr_err) begin
        state_d = S_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_d = S_WAIT;
        wcnt_d  = WCNT_INIT;
      end else begin
        state_d = S_ACCESS;
      end
    end
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      wcnt_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      write_q <= write_d;
      wcnt_q  <= wcnt_d;
      perr_q  <= perr_d;
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (we) mem_q[idx_q] <= wr_word;
  end

  assign s.s_hreadyout_o = ready;
  assign s.s_hresp_o     = resp;
  assign s.s_perr_o      = perr_q;
  assign s.s_hrdata_o    = rd_en ? stored_d : 32'd0;
  assign s.s_hrdcheck_o  = rd_en ? stored_c : 7'd0;

endmodule
